// File: rtl/seq_bin2bcd_converter_if.sv
// Handshake/result bundle for the sequential binary-to-BCD converter.
// master drives start/bin; slave (the converter) returns busy/done and the result.
interface seq_bin2bcd_converter_if #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [W-1:0]          bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign;
  logic                  ovf;

  modport master (output start, bin, input  busy, done, bcd, sign, ovf);
  modport slave  (input  start, bin, output busy, done, bcd, sign, ovf);
endinterface

// File: rtl/seq_bin2bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement (magnitude + sign).
module seq_bin2bcd_converter #(
  parameter int unsigned W      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_bin2bcd_converter_if.slave  bus
);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    op_q,   op_nxt;
  logic [BW-1:0]   scr_q,  scr_nxt;
  logic [BW-1:0]   adj;
  logic [CW-1:0]   cnt_q,  cnt_nxt;
  logic            acc_q,  acc_nxt;
  logic            sgn_q,  sgn_nxt;
  logic            busy_q, busy_nxt;
  logic            done_q, done_nxt;
  logic [BW-1:0]   bcd_q,  bcd_nxt;
  logic            sign_q, sign_nxt;
  logic            ovf_q,  ovf_nxt;
  logic [W-1:0]    mag;
  logic            mag_sgn;

  // Operand magnitude and sign as captured on acceptance
`ifdef BIN2BCD_SIGNED_EN
  always_comb begin
    mag_sgn = bus.bin[W-1];
    mag     = bus.bin[W-1] ? ((~bus.bin) + W'(1)) : bus.bin;
  end
`else
  always_comb begin
    mag_sgn = 1'b0;
    mag     = bus.bin;
  end
`endif

  // Add-3 correction of every scratch digit that is 5 or more
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? (scr_q[4*i +: 4] + 4'd3)
                                                : scr_q[4*i +: 4];
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= 1'b0;
      sgn_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
      sign_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      scr_q  <= scr_nxt;
      cnt_q  <= cnt_nxt;
      acc_q  <= acc_nxt;
      sgn_q  <= sgn_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      bcd_q  <= bcd_nxt;
      sign_q <= sign_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

  // Next state: leave SHIFT after the W-th shift
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    op_nxt   = op_q;
    scr_nxt  = scr_q;
    cnt_nxt  = cnt_q;
    acc_nxt  = acc_q;
    sgn_nxt  = sgn_q;
    bcd_nxt  = bcd_q;
    sign_nxt = sign_q;
    ovf_nxt  = ovf_q;
    done_nxt = 1'b0;
    busy_nxt = (state_nxt == SHIFT);
    case (state)
      IDLE: begin
        if (bus.start) begin
          op_nxt  = mag;
          sgn_nxt = mag_sgn;
          scr_nxt = '0;
          acc_nxt = 1'b0;
          cnt_nxt = CW'(W);
        end
      end
      SHIFT: begin
        scr_nxt = {adj[BW-2:0], op_q[W-1]};
        op_nxt  = {op_q[W-2:0], 1'b0};
        acc_nxt = acc_q | adj[BW-1];
        cnt_nxt = cnt_q - CW'(1);
        // Publish the result on the final shift so no partial value is visible
        if (cnt_q == CW'(1)) begin
          bcd_nxt  = scr_nxt;
          ovf_nxt  = acc_nxt;
          sign_nxt = sgn_q;
          done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.sign = sign_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: doc/seq_bin2bcd_converter.md
SEQ_BIN2BCD_CONVERTER -- requirements
Module: seq_bin2bcd_converter

Interface
REQ-001 Parameter W, default 8: binary input width; legal range 4..32.
REQ-002 Parameter DIGITS, default 3: number of BCD output digits; legal range 1..10.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port start  input  1: request a conversion of bin.
REQ-006 Port bin  input  W: binary operand, sampled only on the accepting edge.
REQ-007 Port busy  output  1: high while a conversion is in progress.
REQ-008 Port done  output  1: one-cycle pulse when bcd, sign and ovf update.
REQ-009 Port bcd  output  4*DIGITS: packed result; digit 0 (units) in bits [3:0].
REQ-010 Port sign  output  1: result is negative (signed mode only).
REQ-011 Port ovf  output  1: result magnitude did not fit in DIGITS digits.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and SHIFT; busy=1 exactly in SHIFT.
REQ-013 In IDLE, start=1 at a rising edge SHALL be accepted: capture the operand magnitude into a W-bit shift register, clear the 4*DIGITS scratch register, clear the overflow accumulator, load the bit counter with W, and enter SHIFT.
REQ-014 start while in SHIFT SHALL be ignored; there is no queueing.
REQ-015 Each SHIFT edge SHALL first add 3 to every scratch digit whose value is >=5, then shift {scratch, operand} left by one bit, and decrement the counter.
REQ-016 A 1 shifted out of the top scratch bit SHALL set the overflow accumulator.
REQ-017 On the W-th SHIFT edge, the block SHALL, at that same edge: load bcd with the final scratch value (including that edge's shift), ovf with the accumulator, and sign with the captured sign; assert done for the following cycle; and return to IDLE.
REQ-018 Latency: if start is accepted at edge E0, done SHALL be high between edges EW and EW+1; a new start sampled at EW+1 SHALL be accepted, giving a throughput of one conversion per W+1 cycles.
REQ-019 bcd, sign and ovf SHALL hold their values between done pulses and SHALL never show intermediate values.
REQ-020 When ovf=1, bcd SHALL hold the low DIGITS digits of the true decimal value (value mod 10^DIGITS).
REQ-021 Every bcd digit SHALL lie in the range 0..9 at all times.

Reset
REQ-022 rst=1 SHALL immediately force IDLE, busy=0, done=0, bcd=0, sign=0, ovf=0, the counter to 0, and the scratch register to 0.
REQ-023 rst asserted mid-conversion SHALL abandon that conversion; no done pulse SHALL follow for it.
REQ-024 After rst deasserts, the first start sampled at a rising edge SHALL be accepted normally.

Configuration
REQ-025 Macro BIN2BCD_SIGNED_EN defined: bin SHALL be treated as two's complement. On acceptance, magnitude = (bin[W-1] ? -bin : bin) as a W-bit unsigned value, so -2^(W-1) converts to 2^(W-1). sign is captured as bin[W-1].
REQ-026 Macro BIN2BCD_SIGNED_EN undefined: bin SHALL be unsigned and sign SHALL be constant 0. The port list is identical in both builds.

Verification
REQ-027 W=8, DIGITS=3, unsigned, bin=8'd255, start pulsed -> busy for 8 cycles, then done for one cycle with bcd=12'h255 and ovf=0.
REQ-028 bin=0 -> bcd=12'h000 and ovf=0. Back-to-back start of 8'd99 then 8'd100, with the second start sampled on the cycle after done -> bcd=12'h099, then 12'h100 exactly 9 cycles later.
REQ-029 start re-pulsed with bin=8'd7 while busy converting 8'd200 -> single done with bcd=12'h200; no second done follows.
REQ-030 rst pulsed at cycle 4 of a conversion -> busy=0, bcd=0, no done. The next start with 8'd42 -> bcd=12'h042.
REQ-031 W=8, DIGITS=2, bin=8'd123 -> ovf=1 and bcd=8'h23. Then bin=8'd99 -> ovf=0 and bcd=8'h99.
REQ-032 BIN2BCD_SIGNED_EN defined, W=8, DIGITS=3: bin=8'h80 -> sign=1, bcd=12'h128. bin=8'hFF -> sign=1, bcd=12'h001. bin=8'h7F -> sign=0, bcd=12'h127.
